// File: rtl/row_dot_product_mac.sv
// One fully connected row: signed dot product of a 784-pixel image with a
// 784-entry weight row, two pixel/weight pairs per cycle, saturated 32-bit result.
module row_dot_product_mac #(
  parameter int NUM_PAIRS = 392,
  parameter int NUM_ROWS  = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [3:0]  row_select,
  input  logic        begin_mult,
  input  logic [15:0] pixel_value,
  input  logic [31:0] weight_value,
  output logic [9:0]  pixel_address,
  output logic [11:0] weight_address,
  output logic        done_row,
  output logic [31:0] row_result,
  output logic        overflow,
  output logic        w_result_ena
);

  localparam int          ROW_W   = $clog2(NUM_ROWS);
  localparam logic [9:0]  K_LAST  = 10'(NUM_PAIRS - 1);
  localparam logic [11:0] PAIRS12 = 12'(NUM_PAIRS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             r_state;
  logic [9:0]         r_k;
  logic [ROW_W-1:0]   r_row;
  logic signed [39:0] r_acc;
  logic [31:0]        r_row_result;
  logic               r_overflow;
  logic               r_done;

  logic signed [24:0] w_prod_hi;
  logic signed [24:0] w_prod_lo;
  logic signed [39:0] w_pair_sum;
  logic [11:0]        w_wbase;
  logic               w_ovf;
  logic [31:0]        w_sat;

  // Pixels are unsigned, so they enter the multiply zero-extended.
  assign w_prod_hi  = $signed({16'd0, pixel_value[15:8]}) *
                      $signed({{9{weight_value[31]}}, weight_value[31:16]});
  assign w_prod_lo  = $signed({16'd0, pixel_value[7:0]}) *
                      $signed({{9{weight_value[15]}}, weight_value[15:0]});
  assign w_pair_sum = {{15{w_prod_hi[24]}}, w_prod_hi} +
                      {{15{w_prod_lo[24]}}, w_prod_lo};

  // The sum fits in 32 bits only when bits 39..31 are all copies of the sign.
  assign w_ovf = !((&r_acc[39:31]) || (~|r_acc[39:31]));
  assign w_sat = w_ovf ? (r_acc[39] ? 32'h8000_0000 : 32'h7FFF_FFFF) : r_acc[31:0];

  assign w_wbase        = {{(12 - ROW_W){1'b0}}, r_row} * PAIRS12;
  assign pixel_address  = (r_state == ACCUM) ? r_k : 10'd0;
  assign weight_address = (r_state == ACCUM) ? (w_wbase + {2'b00, r_k}) : 12'd0;

  assign done_row     = r_done;
  assign w_result_ena = r_done;
  assign row_result   = r_row_result;
  assign overflow     = r_overflow;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_row        <= '0;
      r_acc        <= '0;
      r_row_result <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (begin_mult) begin
            r_row        <= row_select[ROW_W-1:0];
            r_acc        <= '0;
            r_row_result <= '0;
            r_overflow   <= 1'b0;
            r_k          <= '0;
            r_state      <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc <= r_acc + w_pair_sum;
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_state <= DONE;
          end else begin
            r_k <= r_k + 10'd1;
          end
        end
        DONE: begin
          r_done       <= 1'b1;
          r_row_result <= w_sat;
          r_overflow   <= w_ovf;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_dot_product_mac.sv
// Scoreboard bench for row_dot_product_mac: directed rows with hand-computed
// results; a negedge monitor pops expectations whenever done_row is seen.
module tb_row_dot_product_mac;

  logic        clk;
  logic        n_rst;
  logic [3:0]  row_select;
  logic        begin_mult;
  logic [15:0] pixel_value;
  logic [31:0] weight_value;
  logic [9:0]  pixel_address;
  logic [11:0] weight_address;
  logic        done_row;
  logic [31:0] row_result;
  logic        overflow;
  logic        w_result_ena;

  logic [15:0] pixelMem  [0:1023];
  logic [31:0] weightMem [0:4095];

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          doneCyc;
  } exp_t;

  exp_t sbQ[$];
  int   cyc       = 0;
  int   checks    = 0;
  int   failures  = 0;

  row_dot_product_mac #(.NUM_PAIRS(392), .NUM_ROWS(10)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .row_select     (row_select),
    .begin_mult     (begin_mult),
    .pixel_value    (pixel_value),
    .weight_value   (weight_value),
    .pixel_address  (pixel_address),
    .weight_address (weight_address),
    .done_row       (done_row),
    .row_result     (row_result),
    .overflow       (overflow),
    .w_result_ena   (w_result_ena)
  );

  // Combinational memories; anything outside the loaded row reads a poison word.
  assign pixel_value  = pixelMem[pixel_address];
  assign weight_value = weightMem[weight_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h) at cycle %0d",
               name, $signed(act), act, $signed(exp), exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic loadRow(input int row, input logic [7:0] phi, input logic [7:0] plo,
                         input logic [15:0] whi, input logic [15:0] wlo);
    for (int i = 0; i < 1024; i++) pixelMem[i] = (i < 392) ? {phi, plo} : 16'hABCD;
    for (int i = 0; i < 4096; i++) weightMem[i] = 32'h1357_2468;
    for (int i = 0; i < 392; i++) weightMem[(row * 392 + i) % 4096] = {whi, wlo};
  endtask

  // Runs one full row, checking addresses along the way; the result itself is
  // checked by the monitor from the scoreboard entry pushed here.
  task automatic applyStimulus(input int row, input logic [7:0] phi, input logic [7:0] plo,
                               input logic [15:0] whi, input logic [15:0] wlo,
                               input logic [31:0] expRes, input logic expOvf, input bit midPulse);
    exp_t e;
    int   base;
    bit   seen;
    base = (row * 392) % 4096;
    loadRow(row, phi, plo, whi, wlo);
    e.res     = expRes;
    e.ovf     = expOvf;
    e.doneCyc = cyc + 394;
    sbQ.push_back(e);
    row_select = 4'(row);
    begin_mult = 1'b1;
    @(negedge clk);
    begin_mult = 1'b0;
    checkOutput("pixAddrFirst", 32'(pixel_address), 32'd0);
    checkOutput("wAddrFirst", 32'(weight_address), 32'(base));
    checkOutput("ovfClearedOnBegin", 32'(overflow), 32'd0);
    for (int i = 1; i < 392; i++) begin
      @(negedge clk);
      begin_mult = (midPulse && i == 50);
    end
    begin_mult = 1'b0;
    checkOutput("pixAddrLast", 32'(pixel_address), 32'd391);
    checkOutput("wAddrLast", 32'(weight_address), 32'((base + 391) % 4096));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = done_row;
    end
    if (!seen) begin
      failNow("doneTimeout");
      if (sbQ.size() != 0) void'(sbQ.pop_front());
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!n_rst) begin
      if (done_row) begin
        if (sbQ.size() == 0) begin
          failNow("unexpectedDone");
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("rowResult", row_result, e.res);
          checkOutput("overflow", 32'(overflow), 32'(e.ovf));
          checkOutput("resultEna", 32'(w_result_ena), 32'd1);
          checkOutput("latency", 32'(cyc), 32'(e.doneCyc));
        end
      end else if (w_result_ena) begin
        failNow("strayResultEna");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_rst      = 1'b1;
    begin_mult = 1'b0;
    row_select = 4'd0;
    loadRow(0, 8'd0, 8'd0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    checkOutput("rstDone", 32'(done_row), 32'd0);
    checkOutput("rstEna", 32'(w_result_ena), 32'd0);
    checkOutput("rstResult", row_result, 32'd0);
    checkOutput("rstOvf", 32'(overflow), 32'd0);
    checkOutput("rstPixAddr", 32'(pixel_address), 32'd0);
    checkOutput("rstWAddr", 32'(weight_address), 32'd0);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(0,  8'd1,   8'd1,   16'd1,     16'd1,     32'd784,       1'b0, 1'b0);
    applyStimulus(1,  8'd5,   8'd2,   16'd7,     16'd9,     32'd20776,     1'b0, 1'b0);
    applyStimulus(9,  8'd10,  8'd200, 16'd100,   16'hFFFD,  32'd156800,    1'b0, 1'b0);
    applyStimulus(15, 8'd1,   8'd1,   16'd1,     16'd1,     32'd784,       1'b0, 1'b0);
    applyStimulus(1,  8'd255, 8'd255, 16'd30000, 16'd30000, 32'h7FFF_FFFF, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("holdResult", row_result, 32'h7FFF_FFFF);
      checkOutput("holdOvf", 32'(overflow), 32'd1);
    end

    applyStimulus(2,  8'd1,   8'd1,   16'hFF00,  16'h0000,  32'hFFFE_7800, 1'b0, 1'b0);
    applyStimulus(3,  8'd255, 8'd255, 16'h8000,  16'h8000,  32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(4,  8'd5,   8'd2,   16'd7,     16'd9,     32'd20776,     1'b0, 1'b1);

    // Abort a row with reset partway through; no result may follow.
    begin
      exp_t e;
      loadRow(1, 8'd255, 8'd255, 16'd30000, 16'd30000);
      e.res = 32'h7FFF_FFFF; e.ovf = 1'b1; e.doneCyc = cyc + 394;
      sbQ.push_back(e);
      row_select = 4'd1;
      begin_mult = 1'b1;
      @(negedge clk);
      begin_mult = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("midRowPixAddr", 32'(pixel_address), 32'd100);
      #2 n_rst = 1'b1;
      #1;
      checkOutput("abortDone", 32'(done_row), 32'd0);
      checkOutput("abortResult", row_result, 32'd0);
      checkOutput("abortOvf", 32'(overflow), 32'd0);
      checkOutput("abortPixAddr", 32'(pixel_address), 32'd0);
      checkOutput("abortWAddr", 32'(weight_address), 32'd0);
      void'(sbQ.pop_back());
      @(negedge clk);
      n_rst = 1'b0;
      repeat (400) @(negedge clk);
    end

    applyStimulus(0,  8'd5,   8'd2,   16'd7,     16'd9,     32'd20776,     1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_dot_product_mac.md
Name: row_dot_product_mac

Overview:
- Computes one row of a fully connected layer: a signed dot product of a 784-pixel image (28x28, 8-bit unsigned pixels) with one 784-entry row of signed 16-bit weights.
- Each cycle it reads two pixels and two weights from external pixel and weight memories and accumulates both products.
- Produces a 32-bit signed row result, an overflow flag and a write-enable pulse for the result memory.
- Sits between the image/weight buffers and the result store in the inference datapath.

Parameters:
- NUM_PAIRS, 392, number of two-element reads per row (784/2).
- NUM_ROWS, 10, number of valid weight rows.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous reset, active-high (asserted = 1) despite the name; clears all state immediately.
- row_select  in  4  weight row index; sampled when begin_mult is accepted.
- begin_mult  in  1  start request; single-cycle pulse, sampled at a rising edge.
- pixel_value  in  16  [15:8] = pixel at even index 2k, [7:0] = pixel at index 2k+1; unsigned.
- weight_value  in  32  [31:16] = weight 2k, [15:0] = weight 2k+1; two's-complement signed.
- pixel_address  out  10  pair index k into pixel memory, range 0..391.
- weight_address  out  12  row_select*392 + k (modulo 4096).
- done_row  out  1  one-cycle pulse: row_result and overflow are valid.
- row_result  out  32  signed dot-product result, saturated.
- overflow  out  1  set if the true sum is outside the signed 32-bit range.
- w_result_ena  out  1  one-cycle result-memory write strobe, coincident with done_row.

Behaviour:
- Reset values: state IDLE; pair counter 0; accumulator 0; all outputs 0.
- Memory timing:
  - pixel_address and weight_address are driven from registered state.
  - pixel_value and weight_value must present the data for the current address in the same cycle (combinational read).
  - Data is sampled at the next rising edge.
- State IDLE:
  - Addresses are held at 0.
  - On begin_mult=1: latch row_select, clear the accumulator and the overflow flag, and set the pair counter k=0.
  - Go to ACCUM.
- State ACCUM:
  - Each cycle: accumulator += p_hi*w_hi + p_lo*w_lo.
  - Pixels are zero-extended and weights sign-extended; the accumulator is 40-bit signed, so it cannot wrap internally.
  - k increments each cycle.
  - When the pair at k=391 is accumulated, go to DONE.
  - Exactly 392 accumulate cycles.
- State DONE (one cycle):
  - done_row=1 and w_result_ena=1.
  - row_result is the accumulator saturated to [-2^31, 2^31-1].
  - overflow=1 if the final accumulator is outside that range.
  - Go to IDLE.
- Latency: done_row asserts 393 cycles after the edge that samples begin_mult. A new begin is accepted the cycle after DONE.
- row_result and overflow hold their values after DONE until the next accepted begin_mult.
- Overflow is evaluated on the full 40-bit final sum.
- begin_mult while in ACCUM or DONE is ignored; it does not restart the row.
- row_select values 10..15 are not checked; the address wraps modulo 4096.
- Reset asserted mid-row aborts immediately to IDLE with outputs cleared; no done_row is produced.
- Zero weights or pixels need no special handling; products are 0.

Test Plan:
- Pixels 1,1; weights 1,1; row_select 0 -> weight_address sweeps 0..391; done_row after 393 cycles; row_result=784; overflow=0; w_result_ena pulses with done_row.
- Pixels 5,2; weights 7,9; row_select 1 -> weight_address 392..783; row_result=(35+18)*392=20776; overflow=0.
- Pixels 255,255; weights 30000,30000; row_select 1 -> true sum 5,997,600,000; overflow=1; row_result=2147483647.
- Pixels 1,1; weights 0xFF00 (-256), 0x0000 -> row_result=-100352 (0xFFFE7800); overflow=0.
- begin_mult pulsed again mid-row -> ignored; result identical to a single run. n_rst asserted mid-row -> all outputs 0 immediately; a subsequent begin_mult yields a correct result.
- Result persistence -> row_result, overflow stable for 20 cycles after done_row; the next begin_mult clears overflow.
